wb_master_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the Amber core test environment.
- Master 0 is the Amber core bus (o_wb_* / i_wb_*); master 1 is the bench-side stimulus/loader port; the slave side drives the memory/instruction model.
- Grant is held for the full o_wb_cyc burst; arbitration is round-robin or fixed priority.
- A watchdog returns an error to the granted master when the slave stalls too long.

---
 rtl/wb_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter
// Brief    : Two-master / one-slave Wishbone arbiter. The grant is held for a
//            whole cyc burst. Round-robin or fixed priority. A stall watchdog
//            answers the owner with a forced error when the slave stalls.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_m0_adr,
  input  logic [SEL_W-1:0]  i_m0_sel,
  input  logic              i_m0_we,
  input  logic [DATA_W-1:0] i_m0_dat,
  input  logic              i_m0_cyc,
  input  logic              i_m0_stb,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic [ADDR_W-1:0] i_m1_adr,
  input  logic [SEL_W-1:0]  i_m1_sel,
  input  logic              i_m1_we,
  input  logic [DATA_W-1:0] i_m1_dat,
  input  logic              i_m1_cyc,
  input  logic              i_m1_stb,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [ADDR_W-1:0] o_s_adr,
  output logic [SEL_W-1:0]  o_s_sel,
  output logic              o_s_we,
  output logic [DATA_W-1:0] o_s_dat,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  input  logic [DATA_W-1:0] i_s_dat,
  input  logic              i_s_ack,
  input  logic              i_s_err,
  output logic [1:0]        o_grant,
  output logic [7:0]        o_timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int              WD_W    = 16;
  localparam logic            WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t          state_q, state_d;
  logic            last_q, last_d;     // index of the master served most recently
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      cnt_q, cnt_d;

  logic req0, req1, gnt0, gnt1, own_cyc, own_stb, stall, wd_expire;

  assign req0    = i_m0_cyc & i_m0_stb;
  assign req1    = i_m1_cyc & i_m1_stb;
  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign own_cyc = (gnt0 & i_m0_cyc) | (gnt1 & i_m1_cyc);
  assign own_stb = (gnt0 & i_m0_stb) | (gnt1 & i_m1_stb);
  assign stall   = own_stb & ~i_s_ack & ~i_s_err;
  // A slave response in the expiry cycle wins because stall is then low.
  assign wd_expire = WD_EN & stall & (wd_q == WD_LAST);

  assign o_grant       = {gnt1, gnt0};
  assign o_timeout_cnt = cnt_q;

  // Next-state, grant decision, bus muxing and watchdog bookkeeping.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    o_s_adr  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_dat  = '0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = ((FIXED_PRIORITY != 0) || last_q) ? GNT0 : GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        o_s_adr  = i_m0_adr;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_dat  = i_m0_dat;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb & ~wd_expire;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err | wd_expire;
        if (!i_m0_cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        o_s_adr  = i_m1_adr;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_dat  = i_m1_dat;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb & ~wd_expire;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err | wd_expire;
        if (!i_m1_cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog restarts on any response, on expiry, or when the owner leaves.
    if (!WD_EN || !own_cyc || i_s_ack || i_s_err || wd_expire) begin
      wd_d = '0;
    end else if (stall) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    cnt_d = (wd_expire && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  end

  // State, fairness pointer, watchdog and error-count registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arbiter
// Brief    : Self-checking bench for wb_master_arbiter (round-robin instance
//            plus a fixed-priority instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err;

  logic [31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cyc, o_s_stb;
  logic [3:0]  o_s_sel;
  logic [1:0]  o_grant;
  logic [7:0]  o_to_cnt;

  logic [31:0] f_m0_dat, f_m1_dat, f_s_adr, f_s_dat;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_s_we, f_s_cyc, f_s_stb;
  logic [3:0]  f_s_sel;
  logic [1:0]  f_grant;
  logic [7:0]  f_to_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIORITY(0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_dat(m0_dat),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(m1_adr), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_dat(m1_dat),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_dat(o_s_dat),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(o_grant), .o_timeout_cnt(o_to_cnt)
  );

  wb_master_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIORITY(1)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_dat(m0_dat),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .o_m0_dat(f_m0_dat), .o_m0_ack(f_m0_ack), .o_m0_err(f_m0_err),
    .i_m1_adr(m1_adr), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_dat(m1_dat),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .o_m1_dat(f_m1_dat), .o_m1_ack(f_m1_ack), .o_m1_err(f_m1_err),
    .o_s_adr(f_s_adr), .o_s_sel(f_s_sel), .o_s_we(f_s_we), .o_s_dat(f_s_dat),
    .o_s_cyc(f_s_cyc), .o_s_stb(f_s_stb),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(f_grant), .o_timeout_cnt(f_to_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard side: every ack seen by a master must match a queued read value.
  always @(negedge clk) begin
    if (o_m0_ack === 1'b1) begin
      if (q0.size() == 0) check_eq("m0_spurious_ack", {31'b0, o_m0_ack}, 32'h0);
      else                check_eq("m0_rdata", o_m0_dat, q0.pop_front());
    end
    if (o_m1_ack === 1'b1) begin
      if (q1.size() == 0) check_eq("m1_spurious_ack", {31'b0, o_m1_ack}, 32'h0);
      else                check_eq("m1_rdata", o_m1_dat, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();
    check_eq("rst_grant", {30'b0, o_grant}, 32'h0);
    check_eq("rst_s_cyc", {31'b0, o_s_cyc}, 32'h0);
    check_eq("rst_s_stb", {31'b0, o_s_stb}, 32'h0);
    check_eq("rst_to_cnt", {24'b0, o_to_cnt}, 32'h0);

    // Single master-0 read
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    settle();
    check_eq("t1_no_stb_in_idle", {31'b0, o_s_stb}, 32'h0);
    step();
    check_eq("t1_grant", {30'b0, o_grant}, 32'h1);
    check_eq("t1_s_stb", {31'b0, o_s_stb}, 32'h1);
    check_eq("t1_s_adr", o_s_adr, 32'h100);
    step();
    q0.push_back(32'hE3A01005);
    s_ack = 1'b1; s_dat = 32'hE3A01005;
    settle();
    check_eq("t1_m0_ack", {31'b0, o_m0_ack}, 32'h1);
    check_eq("t1_m1_ack", {31'b0, o_m1_ack}, 32'h0);
    step();
    s_ack = 1'b0; s_dat = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check_eq("t1_release", {30'b0, o_grant}, 32'h0);

    // Round-robin tie and alternation
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    settle();
    step();
    check_eq("t2_first_m0", {30'b0, o_grant}, 32'h1);
    q0.push_back(32'h11111111);
    s_ack = 1'b1; s_dat = 32'h11111111;
    settle();
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    check_eq("t2_idle_gap", {30'b0, o_grant}, 32'h0);
    step();
    check_eq("t2_gnt1", {30'b0, o_grant}, 32'h2);
    q1.push_back(32'h22222222);
    s_ack = 1'b1; s_dat = 32'h22222222;
    settle();
    check_eq("t2_m0_stalled", {31'b0, o_m0_ack}, 32'h0);
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check_eq("t2_alternate_m0", {30'b0, o_grant}, 32'h1);
    idle_inputs();
    step();
    step();

    // Fixed priority: master 0 re-requests every burst
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    check_eq("t3_fp_first", {30'b0, f_grant}, 32'h1);
    for (int b = 1; b <= 3; b++) begin
      m0_cyc = 1'b0; m0_stb = 1'b0;
      step();
      check_eq("t3_fp_gap", {30'b0, f_grant}, 32'h0);
      m0_cyc = 1'b1; m0_stb = 1'b1;
      step();
      check_eq("t3_fp_burst_m0", {30'b0, f_grant}, 32'h1);
      if (b == 1) check_eq("t3_rr_contrast", {30'b0, o_grant}, 32'h2);
    end
    idle_inputs();
    step();

    // Watchdog expiry on a master-1 write that is never acked
    do_reset();
    m1_adr = 32'h300; m1_sel = 4'hF; m1_we = 1'b1; m1_dat = 32'hDEADBEEF;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      settle();
      if (k == 1) begin
        check_eq("t4_s_dat", o_s_dat, 32'hDEADBEEF);
        check_eq("t4_s_sel", {28'b0, o_s_sel}, 32'hF);
        check_eq("t4_s_we", {31'b0, o_s_we}, 32'h1);
      end
      if (k < 16) begin
        check_eq("t4_no_early_err", {31'b0, o_m1_err}, 32'h0);
      end else begin
        check_eq("t4_err_pulse", {31'b0, o_m1_err}, 32'h1);
        check_eq("t4_stb_forced_low", {31'b0, o_s_stb}, 32'h0);
        check_eq("t4_cyc_held", {31'b0, o_s_cyc}, 32'h1);
      end
      step();
    end
    check_eq("t4_to_cnt", {24'b0, o_to_cnt}, 32'h1);
    check_eq("t4_err_one_cycle", {31'b0, o_m1_err}, 32'h0);
    check_eq("t4_stb_back", {31'b0, o_s_stb}, 32'h1);

    // Reset while master 1 is waiting in GNT1; both master requests pending
    step();
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_grant_idle", {30'b0, o_grant}, 32'h0);
    check_eq("t6_s_cyc", {31'b0, o_s_cyc}, 32'h0);
    check_eq("t6_to_cnt_clr", {24'b0, o_to_cnt}, 32'h0);
    step();
    check_eq("t6_tie_m0", {30'b0, o_grant}, 32'h1);
    idle_inputs();
    step();
    step();

    // Ack arriving exactly in the expiry cycle suppresses the forced error
    do_reset();
    m1_adr = 32'h300; m1_sel = 4'hF; m1_we = 1'b1; m1_dat = 32'hDEADBEEF;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        q1.push_back(32'h5A5A0001);
        s_ack = 1'b1; s_dat = 32'h5A5A0001;
        settle();
        check_eq("t4b_no_err", {31'b0, o_m1_err}, 32'h0);
        check_eq("t4b_ack", {31'b0, o_m1_ack}, 32'h1);
      end
      step();
    end
    s_ack = 1'b0;
    check_eq("t4b_to_cnt", {24'b0, o_to_cnt}, 32'h0);
    idle_inputs();
    step();
    step();

    // Four-beat master-0 burst while master 1 waits
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h400;
    step();
    for (int b = 0; b < 4; b++) begin
      m0_stb = 1'b1; m0_adr = 32'h200 + 32'(4 * b);
      s_ack = 1'b1; s_dat = 32'hA0 + 32'(b);
      q0.push_back(32'hA0 + 32'(b));
      settle();
      check_eq("t5_beat_grant", {30'b0, o_grant}, 32'h1);
      check_eq("t5_beat_adr", o_s_adr, 32'h200 + 32'(4 * b));
      check_eq("t5_m1_stalled", {31'b0, o_m1_ack}, 32'h0);
      step();
      s_ack = 1'b0; m0_stb = 1'b0;
      settle();
      check_eq("t5_gap_grant", {30'b0, o_grant}, 32'h1);
      step();
    end
    m0_cyc = 1'b0;
    step();
    check_eq("t5_idle_gap", {30'b0, o_grant}, 32'h0);
    step();
    check_eq("t5_m1_granted", {30'b0, o_grant}, 32'h2);
    idle_inputs();
    step();
    step();

    check_eq("sb0_drained", 32'(q0.size()), 32'h0);
    check_eq("sb1_drained", 32'(q1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
